relu_seq: RTL

Sequential ReLU layer controller for secret-shared activations. It captures a vector of K shared elements on a start request and streams them, one element per cycle, through a single shared ReLU-with-remask datapath. Each result lands in a packed output register, and the block signals completion with a one-cycle done pulse. It sits between the layer-level garbled-circuit sequencer and the per-element ReLU arithmetic, so a whole activation vector costs one datapath instead of K.

---
 rtl/relu_seq_if.sv | 27 ++
 rtl/relu_seq.sv | 111 +++++++++++
 2 files changed

// File: rtl/relu_seq_if.sv
// Handshake and data bundle between the layer sequencer and the relu_seq
// controller. The master side issues start plus the shared input vectors;
// the slave side returns the packed results and status.
interface relu_seq_if #(
    parameter int N = 32,
    parameter int K = 4
);
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    logic              start;
    logic [2*N*K-1:0]  g_input;
    logic [N*K-1:0]    e_input;
    logic [N*K-1:0]    o;
    logic              busy;
    logic              done;
    logic [IW-1:0]     idx;

    modport master (
        output start, g_input, e_input,
        input  o, busy, done, idx
    );

    modport slave (
        input  start, g_input, e_input,
        output o, busy, done, idx
    );
endinterface

// File: rtl/relu_seq.sv
// Sequential ReLU-with-remask controller. A start in IDLE captures K shared
// elements; one shared datapath then processes one element per cycle and
// writes it into its lane of the packed result register. A single-cycle DONE
// state announces that every lane is valid.
module relu_seq #(
    parameter int N = 32,
    parameter int K = 4
) (
    input  logic        clk,
    input  logic        rst,
    relu_seq_if.slave   bus
);
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [2*N*K-1:0]   g_buf_p0;
    logic [N*K-1:0]     e_buf_p0;
    logic [N*K-1:0]     o_p1;
    logic [IW-1:0]      idx_q;
    logic [N-1:0]       r1_cur;
    logic [N-1:0]       r2_cur;
    logic [N-1:0]       e_cur;
    logic [N-1:0]       res_cur;

    // The carry out of r1 + e tells whether x was non-negative in the offset
    // encoding; the low N bits are then x itself, otherwise ReLU gives zero.
    function automatic logic [N-1:0] relu_remask(input logic [N-1:0] r1,
                                                 input logic [N-1:0] e,
                                                 input logic [N-1:0] r2);
        logic [N:0]   sum;
        logic [N-1:0] relu_x;
        sum    = {1'b0, r1} + {1'b0, e};
        relu_x = sum[N] ? sum[N-1:0] : '0;
        return relu_x + r2;
    endfunction

    // Select the captured shares of the element currently addressed by idx.
    always_comb begin
        r1_cur = '0;
        r2_cur = '0;
        e_cur  = '0;
        for (int i = 0; i < K; i++) begin
            if (idx_q == IW'(i)) begin
                r1_cur = g_buf_p0[2*N*i + N +: N];
                r2_cur = g_buf_p0[2*N*i +: N];
                e_cur  = e_buf_p0[N*i +: N];
            end
        end
        res_cur = relu_remask(r1_cur, e_cur, r2_cur);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (idx_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture buffers on an accepted start, then write one result lane per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            g_buf_p0 <= '0;
            e_buf_p0 <= '0;
            o_p1     <= '0;
            idx_q    <= '0;
        end else begin
            // ---- stage p0: capture inputs, clear results ----
            if (state_q == IDLE && bus.start) begin
                g_buf_p0 <= bus.g_input;
                e_buf_p0 <= bus.e_input;
                o_p1     <= '0;
                idx_q    <= '0;
            end
            // ---- stage p1: per-element result written into its lane ----
            if (state_q == RUN) begin
                for (int i = 0; i < K; i++) begin
                    if (idx_q == IW'(i)) begin
                        o_p1[N*i +: N] <= res_cur;
                    end
                end
                idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
            end
        end
    end

    assign bus.o    = o_p1;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.idx  = idx_q;
endmodule
